// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage sequencer in front of the ALU.
// Takes one op from decode, holds it steady on the ALU until completion
// (or an illegal-opcode / hang trap), then offers the result to writeback.
module alu_issue_ctrl #(
    parameter int BIT_WIDTH = 32,
    parameter int TAG_WIDTH = 5,
    parameter int TIMEOUT   = 64,
    parameter int DIV_GUARD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_op,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic [BIT_WIDTH-1:0] alu_a,
    output logic [BIT_WIDTH-1:0] alu_b,
    output logic [4:0]           alu_control,
    input  logic                 alu_done,
    input  logic [BIT_WIDTH-1:0] alu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_err,
    output logic                 busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_RMOD = 5'b00100;

    // Legal opcode map: 0x00-0x0E and 0x10-0x15.
    function automatic logic op_is_legal(input logic [4:0] op);
        return (op <= 5'b01110) || ((op >= 5'b10000) && (op <= 5'b10101));
    endfunction

    function automatic logic op_is_multi(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_RMOD);
    endfunction

    logic [1:0]           state_q, state_d;
    logic [4:0]           op_q, op_d;
    logic [BIT_WIDTH-1:0] a_q, a_d;
    logic [BIT_WIDTH-1:0] b_q, b_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] out_result_q, out_result_d;
    logic                 out_err_q, out_err_d;

    logic                 guard_ok;
    logic                 exec_done;

    // Completion qualifier: a divider done is only trusted once the guard
    // window has passed, so a stale done from the previous division is ignored.
    always_comb begin
        guard_ok  = !op_is_multi(op_q) || (int'(cnt_q) >= DIV_GUARD);
        exec_done = alu_done && guard_ok;
    end

    // Next-state, operand latch, result capture and ALU/handshake drive.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;

        in_ready    = 1'b0;
        out_valid   = 1'b0;
        alu_control = OP_ADD;
        alu_a       = '0;
        alu_b       = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d  = in_op;
                    a_d   = in_a;
                    b_d   = in_b;
                    tag_d = in_tag;
                    cnt_d = '0;
                    if (op_is_legal(in_op)) begin
                        state_d = ST_EXEC;
                    end else begin
                        // Illegal ops bypass EXEC so the ALU never sees the code.
                        out_result_d = '0;
                        out_err_d    = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end

            ST_EXEC: begin
                alu_control = op_q;
                alu_a       = a_q;
                alu_b       = b_q;
                cnt_d       = cnt_q + 1'b1;
                if (exec_done) begin
                    out_result_d = alu_result;
                    out_err_d    = 1'b0;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    out_result_d = '0;
                    out_err_d    = 1'b1;
                    state_d      = ST_RESP;
                end
            end

            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
        end
    end

    // Output views of the held response.
    always_comb begin
        out_result = out_result_q;
        out_tag    = tag_q;
        out_err    = out_err_q;
        busy       = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU that has
// an adjustable-latency divider, stale-done injection and hang mode.
module tb_alu_issue_ctrl;

    localparam int BW = 32;
    localparam int TW = 5;
    localparam int TO = 64;
    localparam int DG = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_op = '0;
    logic [BW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic [BW-1:0] alu_a;
    logic [BW-1:0] alu_b;
    logic [4:0]    alu_control;
    logic          alu_done;
    logic [BW-1:0] alu_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic          busy;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .BIT_WIDTH(BW),
        .TAG_WIDTH(TW),
        .TIMEOUT  (TO),
        .DIV_GUARD(DG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_control(alu_control),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    // ---------------- ALU model ----------------
    int div_cnt = 0;
    int div_lat = 8;
    bit hang    = 1'b0;
    bit stale   = 1'b0;

    always @(posedge clk) begin
        if (alu_control == 5'b00011 || alu_control == 5'b00100) div_cnt <= div_cnt + 1;
        else div_cnt <= 0;
    end

    always_comb begin
        alu_done   = 1'b1;
        alu_result = '0;
        case (alu_control)
            5'b00000: alu_result = alu_a + alu_b;
            5'b00001: alu_result = alu_a - alu_b;
            5'b00010: alu_result = alu_a & alu_b;
            5'b00101: alu_result = alu_a | alu_b;
            5'b00011, 5'b00100: begin
                alu_done = (!hang && div_cnt == div_lat - 1) || (stale && div_cnt == 0);
                if (div_cnt == div_lat - 1)
                    alu_result = (alu_control == 5'b00011) ? alu_a / alu_b : alu_a % alu_b;
                else
                    alu_result = 32'hDEADBEEF;
            end
            default:  alu_result = alu_a ^ alu_b;
        endcase
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int accepts  = 0;
    int exp_accepts = 0;

    typedef struct {
        logic [BW-1:0] res;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [4:0]    op;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [TW-1:0] tag;
        logic [BW-1:0] res;
        logic          err;
        int            lat;
        int            bp;
    } vec_t;
    vec_t vecs[15];

    always @(posedge clk) begin
        if (!reset && in_valid && in_ready) accepts <= accepts + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        int hold_err;
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        out_ready = (v.bp == 0);
        in_valid  = 1'b1;
        in_op     = v.op;
        in_a      = v.a;
        in_b      = v.b;
        in_tag    = v.tag;
        @(posedge clk);
        sb.push_back('{res: v.res, tag: v.tag, err: v.err});
        exp_accepts++;
        #1;
        in_valid = 1'b0;
        lat      = 0;
        hold_err = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1 || alu_control !== v.op ||
                alu_a !== v.a || alu_b !== v.b) hold_err++;
            in_op  = 5'($urandom);
            in_a   = $urandom;
            in_b   = $urandom;
            in_tag = 5'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        check("exec_hold", hold_err, 0);
        check("latency", lat, v.lat);
        check("resp_ctl", alu_control, 0);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got no expectation, required one");
        end else begin
            e = sb.pop_front();
            check("out_result", out_result, e.res);
            check("out_tag", out_tag, e.tag);
            check("out_err", out_err, e.err);
            for (int i = 0; i < v.bp; i++) begin
                @(posedge clk);
                #1;
                check("bp_valid", out_valid, 1);
                check("bp_result", out_result, e.res);
                check("bp_in_ready", in_ready, 0);
            end
        end
        if (v.bp != 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("hs_busy", busy, 0);
        check("hs_valid", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t h;
        vecs[0]  = '{5'b00000, 32'd5,          32'd7,          5'd3,  32'd12,         1'b0, 1, 0};
        vecs[1]  = '{5'b00001, 32'd9,          32'd4,          5'd1,  32'd5,          1'b0, 1, 3};
        vecs[2]  = '{5'b00010, 32'h0000F0F0,   32'h0000FF00,   5'd7,  32'h0000F000,   1'b0, 1, 0};
        vecs[3]  = '{5'b00101, 32'h0000000F,   32'h000000F0,   5'd8,  32'h000000FF,   1'b0, 1, 0};
        vecs[4]  = '{5'b00000, 32'hFFFFFFFF,   32'd1,          5'd31, 32'd0,          1'b0, 1, 0};
        vecs[5]  = '{5'b00011, 32'd100,        32'd7,          5'd10, 32'd14,         1'b0, 8, 0};
        vecs[6]  = '{5'b00100, 32'd100,        32'd7,          5'd11, 32'd2,          1'b0, 8, 0};
        vecs[7]  = '{5'b11000, 32'd1,          32'd2,          5'd12, 32'd0,          1'b1, 0, 0};
        vecs[8]  = '{5'b01111, 32'd3,          32'd4,          5'd13, 32'd0,          1'b1, 0, 0};
        vecs[9]  = '{5'b10110, 32'd5,          32'd6,          5'd14, 32'd0,          1'b1, 0, 0};
        vecs[10] = '{5'b11111, 32'd7,          32'd8,          5'd15, 32'd0,          1'b1, 0, 2};
        vecs[11] = '{5'b01110, 32'h0000000A,   32'h00000003,   5'd16, 32'h00000009,   1'b0, 1, 0};
        vecs[12] = '{5'b10000, 32'h0000000F,   32'h00000001,   5'd17, 32'h0000000E,   1'b0, 1, 0};
        vecs[13] = '{5'b10101, 32'd3,          32'd5,          5'd18, 32'd6,          1'b0, 1, 0};
        vecs[14] = '{5'b00110, 32'h000000FF,   32'h0000000F,   5'd19, 32'h000000F0,   1'b0, 1, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        check("rst_alu_ctl", alu_control, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Stale done in the first EXEC cycle must be ignored.
        stale = 1'b1;
        h = '{5'b00011, 32'd100, 32'd7, 5'd20, 32'd14, 1'b0, 8, 0};
        run_op(h);
        stale = 1'b0;

        // Done arriving on the last allowed cycle beats the timeout.
        div_lat = 64;
        h = '{5'b00011, 32'd1000, 32'd10, 5'd21, 32'd100, 1'b0, 64, 0};
        run_op(h);

        // One cycle later is a timeout.
        div_lat = 65;
        h = '{5'b00100, 32'd1000, 32'd7, 5'd22, 32'd0, 1'b1, 64, 0};
        run_op(h);
        div_lat = 8;

        // Hung divider, then a normal op.
        hang = 1'b1;
        h = '{5'b00011, 32'd100, 32'd7, 5'd23, 32'd0, 1'b1, 64, 0};
        run_op(h);
        hang = 1'b0;
        h = '{5'b00000, 32'd1, 32'd2, 5'd24, 32'd3, 1'b0, 1, 0};
        run_op(h);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 5'b00011;
        in_a     = 32'd100;
        in_b     = 32'd7;
        in_tag   = 5'd25;
        @(posedge clk);
        exp_accepts++;
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid_div_ctl", alu_control, 5'b00011);
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_alu_ctl", alu_control, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_b", alu_b, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_result", out_result, 0);
        check("arst_out_tag", out_tag, 0);
        check("arst_out_err", out_err, 0);
        @(negedge clk);
        reset = 1'b0;
        h = '{5'b00000, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1, 0};
        run_op(h);

        repeat (2) @(negedge clk);
        check("accept_count", accepts, exp_accepts);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
